voice_allocator: RTL

Sequential scheduler that shares the three note-player voices between a stream of note requests from the song reader. It accepts one note per valid/ready handshake and assigns it to a free voice, lowest index first. It issues a one-cycle `new_note_*` load pulse with registered note and duration, and tracks per-voice busy state and allocation age. It sits between `song_reader` and the three `note_player` instances and replaces the song reader's ad-hoc combinational voice selection.

---
 rtl/voice_allocator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: shares three note-player voices among song note requests.
// Define VOICE_STEAL_EN to reassign the oldest busy voice when all are busy.
module voice_allocator #(
  parameter int NOTE_WIDTH     = 6,
  parameter int DURATION_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      req_valid,
  input  logic [NOTE_WIDTH-1:0]     req_note,
  input  logic [DURATION_WIDTH-1:0] req_duration,
  output logic                      req_ready,
  input  logic [2:0]                voice_done,
  output logic [NOTE_WIDTH-1:0]     note_one,
  output logic [NOTE_WIDTH-1:0]     note_two,
  output logic [NOTE_WIDTH-1:0]     note_three,
  output logic [DURATION_WIDTH-1:0] duration_one,
  output logic [DURATION_WIDTH-1:0] duration_two,
  output logic [DURATION_WIDTH-1:0] duration_three,
  output logic                      new_note_one,
  output logic                      new_note_two,
  output logic                      new_note_three,
  output logic [2:0]                busy,
  output logic                      all_idle,
  output logic                      stolen
);

  logic [NOTE_WIDTH-1:0]     note_q [3];
  logic [DURATION_WIDTH-1:0] dur_q [3];
  logic [1:0]                rank_q [3];
  logic [2:0]                busy_q;
  logic [2:0]                pulse_q;
  logic [2:0]                sel;
  logic [1:0]                sel_rank;
  logic                      is_rest;
  logic                      alloc;

  assign is_rest = (req_note == '0);

`ifdef VOICE_STEAL_EN
  assign req_ready = play;
`else
  assign req_ready = play && (busy_q != 3'b111 || is_rest);
`endif

  assign alloc = req_valid && req_ready && !is_rest;

  // Lowest free voice first; with stealing, the oldest voice when full.
  always_comb begin
    sel = 3'b000;
    if (!busy_q[0])
      sel = 3'b001;
    else if (!busy_q[1])
      sel = 3'b010;
    else if (!busy_q[2])
      sel = 3'b100;
`ifdef VOICE_STEAL_EN
    else begin
      for (int i = 0; i < 3; i++)
        if (rank_q[i] == 2'd2)
          sel[i] = 1'b1;
    end
`endif
  end

  always_comb begin
    sel_rank = 2'd0;
    for (int i = 0; i < 3; i++)
      if (sel[i])
        sel_rank = rank_q[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= '0;
      pulse_q   <= '0;
      rank_q[0] <= 2'd2;
      rank_q[1] <= 2'd1;
      rank_q[2] <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        note_q[i] <= '0;
        dur_q[i]  <= '0;
      end
    end else begin
      busy_q  <= (busy_q & ~voice_done) | (alloc ? sel : 3'b000);
      pulse_q <= alloc ? sel : 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (alloc && sel[i]) begin
          note_q[i] <= req_note;
          dur_q[i]  <= req_duration;
          rank_q[i] <= 2'd0;
        end else if (alloc && rank_q[i] < sel_rank) begin
          rank_q[i] <= rank_q[i] + 2'd1;
        end
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic stolen_q;

  always_ff @(posedge clk) begin
    if (reset)
      stolen_q <= 1'b0;
    else
      stolen_q <= alloc && (busy_q == 3'b111);
  end

  assign stolen = stolen_q;
`else
  assign stolen = 1'b0;
`endif

  assign busy           = busy_q;
  assign all_idle       = (busy_q == 3'b000) && (pulse_q == 3'b000);
  assign note_one       = note_q[0];
  assign note_two       = note_q[1];
  assign note_three     = note_q[2];
  assign duration_one   = dur_q[0];
  assign duration_two   = dur_q[1];
  assign duration_three = dur_q[2];
  assign new_note_one   = pulse_q[0];
  assign new_note_two   = pulse_q[1];
  assign new_note_three = pulse_q[2];

endmodule
